// File: rtl/sys_defs.sv
// Shared writeback definitions: data width, source count, result request type
// and the fixed source numbering.
package sys_defs;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned N_SRC = 4;

  typedef struct packed {
    logic            valid;
    logic [4:0]      idx;
    logic [XLEN-1:0] data;
  } wb_req_t;

  localparam int unsigned SRC_ALU0 = 0;
  localparam int unsigned SRC_ALU1 = 1;
  localparam int unsigned SRC_MULT = 2;
  localparam int unsigned SRC_MEM  = 3;

endpackage

// File: rtl/wb_age_select.sv
// Oldest-first selection of up to two register-file writes from the pending
// result entries, plus the mask of x0 entries that retire without a write.
module wb_age_select #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned AGE_W = 3
) (
  input  logic [N_SRC-1:0]            pend_i,
  input  logic [N_SRC-1:0][AGE_W-1:0] age_i,
  input  logic [N_SRC-1:0][4:0]       idx_i,
  output logic [N_SRC-1:0]            sel1_o,
  output logic [N_SRC-1:0]            sel2_o,
  output logic [N_SRC-1:0]            drop_o
);

  logic             have1, have2;
  logic [AGE_W-1:0] best1_age, best2_age;
  logic [4:0]       idx1;

  always_comb begin
    sel1_o    = '0;
    sel2_o    = '0;
    drop_o    = '0;
    have1     = 1'b0;
    have2     = 1'b0;
    best1_age = '0;
    best2_age = '0;
    idx1      = '0;

    // Strictly-greater compare while scanning upwards: ties keep the lower index.
    for (int i = 0; i < N_SRC; i++) begin
      drop_o[i] = pend_i[i] && (idx_i[i] == 5'd0);
      if (pend_i[i] && (idx_i[i] != 5'd0) && (!have1 || (age_i[i] > best1_age))) begin
        have1     = 1'b1;
        best1_age = age_i[i];
        idx1      = idx_i[i];
        sel1_o    = '0;
        sel1_o[i] = 1'b1;
      end
    end

    // A same-index entry must wait behind port 1 so the regfile sees WAW order.
    for (int i = 0; i < N_SRC; i++) begin
      if (pend_i[i] && (idx_i[i] != 5'd0) && !sel1_o[i] && (idx_i[i] != idx1) &&
          (!have2 || (age_i[i] > best2_age))) begin
        have2     = 1'b1;
        best2_age = age_i[i];
        sel2_o    = '0;
        sel2_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers one completed result per execution source and drives
// the two register-file write ports oldest-first, retiring x0 results silently.
module wb_arbiter
  import sys_defs::XLEN;
  import sys_defs::wb_req_t;
#(
  parameter int unsigned N_SRC = sys_defs::N_SRC,
  parameter int unsigned AGE_W = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_SRC-1:0]           src_valid,
  input  logic [N_SRC-1:0][4:0]      src_idx,
  input  logic [N_SRC-1:0][XLEN-1:0] src_data,
  output logic [N_SRC-1:0]           src_ready,
  output logic                       write_en_1,
  output logic [4:0]                 write_idx_1,
  output logic [XLEN-1:0]            write_data_1,
  output logic                       write_en_2,
  output logic [4:0]                 write_idx_2,
  output logic [XLEN-1:0]            write_data_2,
  output logic                       busy
);

  localparam logic [AGE_W-1:0] AgeMax = '1;

  wb_req_t [N_SRC-1:0]            ent_q, ent_d;
  logic    [N_SRC-1:0][AGE_W-1:0] age_q, age_d;

  logic [N_SRC-1:0]      pend;
  logic [N_SRC-1:0][4:0] idx;
  logic [N_SRC-1:0]      sel1, sel2, drop, grant;

  always_comb begin
    pend = '0;
    idx  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      pend[i] = ent_q[i].valid;
      idx[i]  = ent_q[i].idx;
    end
  end

  wb_age_select #(
    .N_SRC (N_SRC),
    .AGE_W (AGE_W)
  ) u_select (
    .pend_i (pend),
    .age_i  (age_q),
    .idx_i  (idx),
    .sel1_o (sel1),
    .sel2_o (sel2),
    .drop_o (drop)
  );

  assign grant     = sel1 | sel2 | drop;
  // Grant comes from registered state, so a slot being issued can refill this cycle.
  assign src_ready = ~pend | grant;
  assign busy      = |pend;

  always_comb begin
    ent_d = ent_q;
    age_d = age_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant[i]) begin
        ent_d[i].valid = 1'b0;
        age_d[i]       = '0;
      end else if (pend[i] && (age_q[i] != AgeMax)) begin
        age_d[i] = age_q[i] + 1'b1;
      end
      if (src_valid[i] && src_ready[i]) begin
        ent_d[i].valid = 1'b1;
        ent_d[i].idx   = src_idx[i];
        ent_d[i].data  = src_data[i];
        age_d[i]       = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ent_q <= '0;
      age_q <= '0;
    end else begin
      ent_q <= ent_d;
      age_q <= age_d;
    end
  end

  always_comb begin
    write_en_1   = |sel1;
    write_idx_1  = '0;
    write_data_1 = '0;
    write_en_2   = |sel2;
    write_idx_2  = '0;
    write_data_2 = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel1[i]) begin
        write_idx_1  = ent_q[i].idx;
        write_data_1 = ent_q[i].data;
      end
      if (sel2[i]) begin
        write_idx_2  = ent_q[i].idx;
        write_data_2 = ent_q[i].data;
      end
    end
    // Results still pending when reset hits are discarded, not written.
    if (reset) begin
      write_en_1   = 1'b0;
      write_idx_1  = '0;
      write_data_1 = '0;
      write_en_2   = 1'b0;
      write_idx_2  = '0;
      write_data_2 = '0;
    end
  end

`ifndef SYNTHESIS
  for (genvar g = 0; g < N_SRC; g++) begin : g_idx_chk
    a_idx_known: assert property (@(posedge clock) disable iff (reset)
        (src_valid[g] && src_ready[g]) |-> !$isunknown(src_idx[g]))
      else $error("wb_arbiter: source %0d transfers with unknown destination", g);
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed writeback scenarios followed by
// random traffic, compared against an age-ordered reference model each cycle.
module tb_wb_arbiter;
  import sys_defs::*;

  localparam int unsigned N = N_SRC;
  localparam int          AgeSat = 7;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [N-1:0]           src_valid;
  logic [N-1:0][4:0]      src_idx;
  logic [N-1:0][XLEN-1:0] src_data;
  logic [N-1:0]           src_ready;
  logic                   write_en_1, write_en_2, busy;
  logic [4:0]             write_idx_1, write_idx_2;
  logic [XLEN-1:0]        write_data_1, write_data_2;

  wb_arbiter #(.N_SRC(N), .AGE_W(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .src_valid    (src_valid),
    .src_idx      (src_idx),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .write_en_1   (write_en_1),
    .write_idx_1  (write_idx_1),
    .write_data_1 (write_data_1),
    .write_en_2   (write_en_2),
    .write_idx_2  (write_idx_2),
    .write_data_2 (write_data_2),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Reference state: a buffered result and the cycle it first became visible.
  bit              m_pend [N];
  logic [4:0]      m_idx  [N];
  logic [XLEN-1:0] m_data [N];
  int              m_born [N];
  logic [XLEN-1:0] m_rf   [32];
  logic [XLEN-1:0] dut_rf [32];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic int age_of(int i);
    int a = cyc - m_born[i];
    return (a > AgeSat) ? AgeSat : a;
  endfunction

  // One clock: compare outputs mid-cycle, advance the model, then cross the edge.
  task automatic step();
    int       ord[$];
    int       p1, p2;
    bit       g[N];
    logic [N-1:0] exp_ready;
    logic     e1, e2;
    logic [4:0]      i1, i2;
    logic [XLEN-1:0] d1, d2;
    bit       any;

    @(negedge clock);
    ord = {};
    for (int r = 0; r < (AgeSat + 1) * N; r++)
      for (int i = 0; i < N; i++)
        if (m_pend[i] && ((AgeSat - age_of(i)) * N + i == r)) ord.push_back(i);

    p1 = -1;
    p2 = -1;
    for (int i = 0; i < N; i++) g[i] = 1'b0;
    foreach (ord[k]) begin
      int s = ord[k];
      if (m_idx[s] == 5'd0) g[s] = 1'b1;
      else if (p1 < 0) p1 = s;
      else if (p2 < 0 && m_idx[s] != m_idx[p1]) p2 = s;
    end
    if (p1 >= 0) g[p1] = 1'b1;
    if (p2 >= 0) g[p2] = 1'b1;

    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_ready[i] = !m_pend[i] || g[i];
      any |= m_pend[i];
    end
    e1 = !reset && (p1 >= 0);
    e2 = !reset && (p2 >= 0);
    i1 = e1 ? m_idx[p1] : 5'd0;
    d1 = e1 ? m_data[p1] : '0;
    i2 = e2 ? m_idx[p2] : 5'd0;
    d2 = e2 ? m_data[p2] : '0;

    check("write_en_1", 64'(write_en_1), 64'(e1));
    check("write_idx_1", 64'(write_idx_1), 64'(i1));
    check("write_data_1", 64'(write_data_1), 64'(d1));
    check("write_en_2", 64'(write_en_2), 64'(e2));
    check("write_idx_2", 64'(write_idx_2), 64'(i2));
    check("write_data_2", 64'(write_data_2), 64'(d2));
    check("busy", 64'(busy), 64'(any));
    check("src_ready", 64'(src_ready), 64'(exp_ready));

    // Port 2 wins equal indices in the regfile.
    if (write_en_1) dut_rf[write_idx_1] = write_data_1;
    if (write_en_2) dut_rf[write_idx_2] = write_data_2;

    if (reset) begin
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    end else begin
      if (e1) m_rf[i1] = d1;
      if (e2) m_rf[i2] = d2;
      for (int i = 0; i < N; i++) begin
        if (g[i]) m_pend[i] = 1'b0;
        if (src_valid[i] && exp_ready[i]) begin
          m_pend[i] = 1'b1;
          m_idx[i]  = src_idx[i];
          m_data[i] = src_data[i];
          m_born[i] = cyc + 1;
        end
      end
    end

    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic clr_src();
    src_valid = '0;
    src_idx   = '0;
    src_data  = '0;
  endtask

  task automatic set_src(input int unsigned s, input logic [4:0] ix, input logic [XLEN-1:0] d);
    src_valid[s] = 1'b1;
    src_idx[s]   = ix;
    src_data[s]  = d;
  endtask

  task automatic idle(input int n);
    clr_src();
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      m_rf[r]   = '0;
      dut_rf[r] = '0;
    end
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0;
      m_idx[i]  = '0;
      m_data[i] = '0;
      m_born[i] = 0;
    end
    reset = 1'b1;
    clr_src();
    @(posedge clock);
    #1;
    step();
    step();
    reset = 1'b0;
    idle(1);

    // Two independent results land on both ports the next cycle.
    set_src(SRC_ALU0, 5'd5, 32'hA);
    set_src(SRC_MULT, 5'd7, 32'hB);
    step();
    idle(3);

    // Same destination: older (lower index) first, younger one cycle later.
    set_src(SRC_ALU0, 5'd3, 32'h1);
    set_src(SRC_ALU1, 5'd3, 32'h2);
    step();
    idle(3);
    check("x3_final", 64'(dut_rf[3]), 64'h2);

    // All four sources at once: two issue, the other two stall a cycle.
    for (int unsigned s = 0; s < N; s++) set_src(s, 5'(s + 1), 32'h100 + s);
    step();
    idle(3);

    // x0 result retires without using a port.
    set_src(SRC_MEM, 5'd0, 32'hDEAD);
    set_src(SRC_ALU0, 5'd9, 32'h9);
    step();
    idle(2);
    check("x0_untouched", 64'(dut_rf[0]), 64'h0);

    // Reset while three results are pending: none of them is ever written.
    set_src(SRC_ALU0, 5'd20, 32'h20);
    set_src(SRC_ALU1, 5'd21, 32'h21);
    set_src(SRC_MULT, 5'd22, 32'h22);
    step();
    clr_src();
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle(3);
    check("x20_discarded", 64'(dut_rf[20]), 64'h0);
    check("x22_discarded", 64'(dut_rf[22]), 64'h0);

    // Random traffic with narrow index ranges to force collisions and x0 drops.
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 149) == 0);
      for (int unsigned s = 0; s < N; s++) begin
        src_valid[s] = ($urandom_range(0, 2) != 0);
        src_idx[s]   = (k < 1500) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        src_data[s]  = $urandom;
      end
      step();
    end
    reset = 1'b0;
    idle(4);

    for (int r = 0; r < 32; r++) check($sformatf("rf_x%0d", r), 64'(dut_rf[r]), 64'(m_rf[r]));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
